// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the multi-ported register file
// with its power-up clear sequence and pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int NWR_DEF   = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: x0 mask, same-cycle write bypass (highest port wins) and
// scoreboard busy masking when a same-cycle write retires the producer.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = 5,
  parameter int NWR  = NWR_DEF
) (
  input  logic                active,
  input  logic [AW-1:0]       raddr,
  input  logic [XLEN-1:0]     stored,
  input  logic                busy_stored,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic [XLEN-1:0]     rdata,
  output logic                rbusy
);

  logic [XLEN-1:0] data_s;
  logic            wr_hit_s;
  logic            alloc_hit_s;
  logic            zero_s;

  // Bypass mux and busy mask; later ports override earlier ones.
  always_comb begin
    data_s   = stored;
    wr_hit_s = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      logic hit;
      hit      = we[i] && (waddr[i*AW +: AW] == raddr);
      data_s   = hit ? wdata[i*XLEN +: XLEN] : data_s;
      wr_hit_s = wr_hit_s | hit;
    end
    alloc_hit_s = alloc_en && (alloc_addr == raddr);
    zero_s      = (raddr == '0);
    rdata       = (active && !zero_s) ? data_s : '0;
    rbusy       = active && !zero_s && busy_stored && !(wr_hit_s && !alloc_hit_s);
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file: clears one entry per cycle after reset, then
// serves NWR write ports, NRD bypassing read ports and a busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = NRD_DEF,
  parameter int NWR   = NWR_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic [XLEN-1:0]   mem_q [NREGS];
  logic [XLEN-1:0]   mem_d [NREGS];
  logic [NREGS-1:0]  busy_q, busy_d;

  // Next-state: clear sweep, then writes/scoreboard with alloc overriding a retiring write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    mem_d   = mem_q;
    busy_d  = busy_q;
    case (state_q)
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        busy_d       = '0;
        cnt_d        = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_READY;
          ready_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
          ready_d = 1'b0;
        end
      end
      ST_READY: begin
        for (int i = 0; i < NWR; i++) begin
          logic [AW-1:0] wa;
          wa         = waddr[i*AW +: AW];
          mem_d[wa]  = we[i] ? wdata[i*XLEN +: XLEN] : mem_d[wa];
          busy_d[wa] = busy_d[wa] & ~we[i];
        end
        busy_d[alloc_addr] = busy_d[alloc_addr] | alloc_en;
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
        busy_d  = '0;
      end
    endcase
  end

  // Control and scoreboard state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array; contents are defined by the clear sweep, not by rst.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready = ready_q;

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr[j*AW +: AW];
    regfile_rdport #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_rdport (
      .active      (state_q == ST_READY),
      .raddr       (ra),
      .stored      (mem_q[ra]),
      .busy_stored (busy_q[ra]),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .alloc_en    (alloc_en),
      .alloc_addr  (alloc_addr),
      .rdata       (rdata[j*XLEN +: XLEN]),
      .rbusy       (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: default 2R/2W build plus a
// 4R/3W 64-bit build for write-priority and bypass checks.
module tb_regfile_mp;

  logic        clk;
  logic        rst;

  logic        ready;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        alloc_en;
  logic [4:0]  alloc_addr;

  logic         ready3;
  logic [2:0]   we3;
  logic [14:0]  waddr3;
  logic [191:0] wdata3;
  logic [19:0]  raddr3;
  logic [255:0] rdata3;
  logic [3:0]   rbusy3;
  logic         alloc_en3;
  logic [4:0]   alloc_addr3;

  int n_checks;
  int n_fail;

  regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr)
  );

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(4), .NWR(3)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready3),
    .we         (we3),
    .waddr      (waddr3),
    .wdata      (wdata3),
    .raddr      (raddr3),
    .rdata      (rdata3),
    .rbusy      (rbusy3),
    .alloc_en   (alloc_en3),
    .alloc_addr (alloc_addr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    we = 2'b00; waddr = '0; wdata = '0; alloc_en = 1'b0; alloc_addr = 5'd0;
    we3 = 3'b000; waddr3 = '0; wdata3 = '0; alloc_en3 = 1'b0; alloc_addr3 = 5'd0;
  endtask

  // Called just after rst drops at a negedge; follows the whole clear sweep.
  task automatic wait_clear(input string tag);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++;
      if (ready !== 1'b0 || ready3 !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_ready_low cycle %0d: ready=%b ready3=%b, required 0", tag, k + 1, ready, ready3);
      end
      n_checks++;
      if (rdata !== 64'd0 || rbusy !== 2'b00) begin
        n_fail++;
        $display("FAIL %s_clear_read cycle %0d: rdata=%h rbusy=%b, required 0", tag, k + 1, rdata, rbusy);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (ready !== 1'b1 || ready3 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_high cycle 33: ready=%b ready3=%b, required 1", tag, ready, ready3);
    end
  endtask

  task automatic test_reset();
    idle();
    raddr = {5'd5, 5'd1};
    alloc_en = 1'b1; alloc_addr = 5'd9; we = 2'b11; waddr = {5'd5, 5'd1}; wdata = {32'h1, 32'h2};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_clear("reset");
    idle();
    for (int r = 0; r < 32; r++) begin
      raddr = {5'(r), 5'(31 - r)};
      #1;
      n_checks++;
      if (rdata !== 64'd0 || rbusy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_zero x%0d: rdata=%h rbusy=%b, required 0", r, rdata, rbusy);
      end
    end
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h5555FFFF, 32'hAAAA0000};
    raddr = {5'd0, 5'd5};
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'h5555FFFF) begin
      n_fail++;
      $display("FAIL prio_bypass: rdata=%h, required 5555ffff", rdata[31:0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'h5555FFFF) begin
      n_fail++;
      $display("FAIL prio_stored: rdata=%h, required 5555ffff", rdata[31:0]);
    end
    we = 2'b01; waddr = {5'd0, 5'd6}; wdata = {32'h0, 32'h12345678};
    raddr = {5'd6, 5'd5};
    #1;
    n_checks++;
    if (rdata !== {32'h12345678, 32'h5555FFFF}) begin
      n_fail++;
      $display("FAIL port0_bypass: rdata=%h, required 123456785555ffff", rdata);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rdata !== {32'h12345678, 32'h5555FFFF}) begin
      n_fail++;
      $display("FAIL port0_stored: rdata=%h, required 123456785555ffff", rdata);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'h0, 32'hDEADBEEF};
    raddr = {5'd0, 5'd0};
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'd0 || rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_bypass: rdata=%h rbusy=%b, required 0/0", rdata[31:0], rbusy[0]);
    end
    @(negedge clk);
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd0;
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'd0 || rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write: rdata=%h rbusy=%b, required 0/0", rdata[31:0], rbusy[0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_alloc: rbusy=%b, required 0", rbusy[0]);
    end
  endtask

  task automatic test_busy();
    @(negedge clk);
    alloc_en = 1'b1; alloc_addr = 5'd7;
    raddr = {5'd8, 5'd7};
    #1;
    n_checks++;
    if (rbusy !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_alloc_cycle: rbusy=%b, required 00", rbusy);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rbusy !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_set: rbusy=%b, required 01", rbusy);
    end
    we = 2'b10; waddr = {5'd7, 5'd0}; wdata = {32'hCAFE0001, 32'h0};
    alloc_en = 1'b1; alloc_addr = 5'd7;
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b1 || rdata[31:0] !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL busy_write_alloc: rbusy=%b rdata=%h, required 1/cafe0001", rbusy[0], rdata[31:0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_alloc_wins: rbusy=%b, required 1", rbusy[0]);
    end
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'hBEEF0007};
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'hBEEF0007) begin
      n_fail++;
      $display("FAIL busy_lone_write: rbusy=%b rdata=%h, required 0/beef0007", rbusy[0], rdata[31:0]);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'hBEEF0007) begin
      n_fail++;
      $display("FAIL busy_cleared: rbusy=%b rdata=%h, required 0/beef0007", rbusy[0], rdata[31:0]);
    end
  endtask

  task automatic test_rst_mid_clear();
    @(negedge clk);
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h1};
    @(negedge clk);
    idle();
    raddr = {5'd0, 5'd3};
    #1;
    n_checks++;
    if (rdata[31:0] !== 32'h1) begin
      n_fail++;
      $display("FAIL x3_before_rst: rdata=%h, required 1", rdata[31:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("midclr");
    raddr = {5'd5, 5'd3};
    #1;
    n_checks++;
    if (rdata !== 64'd0) begin
      n_fail++;
      $display("FAIL x3_after_rst: rdata=%h, required 0", rdata);
    end
  endtask

  task automatic test_wide();
    @(negedge clk);
    we3 = 3'b111; waddr3 = {5'd9, 5'd9, 5'd9};
    wdata3 = {64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    raddr3 = {5'd9, 5'd0, 5'd1, 5'd9};
    #1;
    n_checks++;
    if (rdata3[255:192] !== 64'h3333333333333333 || rdata3[63:0] !== 64'h3333333333333333) begin
      n_fail++;
      $display("FAIL wide_prio_bypass: rd3=%h rd0=%h, required 3333333333333333", rdata3[255:192], rdata3[63:0]);
    end
    @(negedge clk);
    we3 = 3'b111; waddr3 = {5'd6, 5'd4, 5'd4};
    wdata3 = {64'h6666000000000006, 64'h4444000000000001, 64'h4444000000000000};
    raddr3 = {5'd9, 5'd6, 5'd4, 5'd0};
    #1;
    n_checks++;
    if (rdata3 !== {64'h3333333333333333, 64'h6666000000000006, 64'h4444000000000001, 64'h0}) begin
      n_fail++;
      $display("FAIL wide_mixed_bypass: rdata3=%h, required 3333333333333333666600000000000644440000000000010000000000000000", rdata3);
    end
    @(negedge clk);
    idle();
    #1;
    n_checks++;
    if (rdata3 !== {64'h3333333333333333, 64'h6666000000000006, 64'h4444000000000001, 64'h0}) begin
      n_fail++;
      $display("FAIL wide_stored: rdata3=%h, required 3333333333333333666600000000000644440000000000010000000000000000", rdata3);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    raddr    = '0;
    raddr3   = '0;
    idle();
    test_reset();
    test_write_priority();
    test_x0();
    test_busy();
    test_rst_mid_clear();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
